// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder controller.
// The master drives the request and operands, and the slave returns status and result.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller.
// Operands are shifted LSB-first through a single full-adder cell, one bit per clock.
// The carry is held in a flip-flop between bits.
// The finished sum, unsigned carry-out and signed overflow flag are presented
// together with a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  // Holds the WIDTH-1 sum bits already produced.
  // The last bit comes straight from the cell on the final edge.
  logic [WIDTH-2:0] acc_sr_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  // Full-adder cell: the same equations as the full_adder_1bit cell, inlined here.
  logic fa_a, fa_b, fa_c_in, fa_s, fa_c_out;
  logic [WIDTH-1:0] acc_next;

  // Cell inputs come from the shift-register LSBs and the carry flop.
  // acc_next is the accumulator with the current sum bit entering at the MSB.
  always_comb begin
    fa_a     = a_sr_q[0];
    fa_b     = b_sr_q[0];
    fa_c_in  = carry_q;
    fa_s     = fa_a ^ fa_b ^ fa_c_in;
    fa_c_out = (fa_a & fa_b) | (fa_c_in & (fa_a ^ fa_b));
    acc_next = {fa_s, acc_sr_q};
  end

  // Control FSM with the datapath registers and the registered status/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      acc_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr_q  <= bus.a_in;
            b_sr_q  <= bus.b_in;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          acc_sr_q <= acc_next[WIDTH-1:1];
          carry_q  <= fa_c_out;
          if (cnt_q == CntLast) begin
            // carry_q is the carry into the MSB here.
            // Its XOR with the MSB carry-out is the signed overflow flag.
            sum_q   <= acc_next;
            cout_q  <= fa_c_out;
            ovf_q   <= carry_q ^ fa_c_out;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial WIDTH-bit adder controller built around one instance of the team's `full_adder_1bit` cell. It feeds the cell's `a`, `b` and `c_in` inputs, and it consumes the cell's `s` and `c_out` outputs. Operands are loaded on a start pulse and shifted LSB-first through the cell, one bit per clock, with the carry held in a flip-flop between bits. The block presents the assembled sum, carry-out and signed-overflow flag with a one-cycle `done` pulse. It is the sequential alternative to the 4-bit ripple-carry adder where area matters more than latency.

## Interface
- `WIDTH`, default 4: operand/sum width in bits; legal range 2–16.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `a_in` input WIDTH: operand A, captured on the accepted start edge.
- `b_in` input WIDTH: operand B, captured on the accepted start edge.
- `cin` input 1: initial carry, captured on the accepted start edge.
- `busy` output 1: high while in SHIFT.
- `done` output 1: one-cycle pulse; result valid.
- `sum` output WIDTH: result, held until the next result is written.
- `cout` output 1: final carry out of the MSB.
- `ovf` output 1: signed overflow (two's complement).

## Operation
- One clock; reset is synchronous and active-high.
- On `reset`:
  - FSM goes to IDLE.
  - `busy`, `done`, `sum`, `cout` and `ovf` are 0.
  - The shift registers, carry flip-flop and bit counter are cleared.
- FSM states are IDLE, SHIFT and DONE.
- **IDLE**
  - `start`=1 → SHIFT.
  - On that edge: `a_sr` loads `a_in`, `b_sr` loads `b_in`, `carry` loads `cin`, `cnt` is cleared to 0.
  - `start`=0 → stay in IDLE.
- **SHIFT** (each cycle)
  - Cell inputs: `a=a_sr[0]`, `b=b_sr[0]`, `c_in=carry`.
  - On the edge:
    - `a_sr` and `b_sr` shift right.
    - `acc_sr` shifts right with the cell's `s` entering at MSB.
    - `carry` takes `c_out`.
    - `cnt` increments.
  - On the cycle with `cnt==WIDTH-1`:
    - `prev_carry` captures `carry`, which is the carry into the MSB.
    - The FSM moves to DONE.
    - On the same edge, `sum` loads the final `acc_sr` value including the current `s`, and `cout` loads `c_out`.
    - `ovf` loads `carry` XOR `c_out`, i.e. the MSB carry-in XOR the MSB carry-out.
- **DONE**
  - `done`=1 for exactly one cycle, then → IDLE unconditionally.
- `start` is ignored in SHIFT and in DONE. It is neither queued nor latched.
- `sum`, `cout` and `ovf` change only on the final SHIFT edge or on reset. They hold their values through IDLE and through the next SHIFT.
- Width rules:
  - `cnt` is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
  - The sum is modulo 2^WIDTH.
  - `cout` is the unsigned carry.
  - `ovf` is set iff the signed operands have the same sign and the sign of `sum` differs from it.

## Timing
- Accepted start at edge T0: `busy`=1 in cycles T0+1 … T0+WIDTH.
- `done`=1 in cycle T0+WIDTH+1.
- `sum`, `cout` and `ovf` are valid from cycle T0+WIDTH+1 onward.
- Latency from the start edge to `done` is WIDTH+1 cycles.
- The earliest next accepted start is at edge T0+WIDTH+2, with the FSM back in IDLE.
- Throughput is one add per WIDTH+2 cycles.
- `busy` and `done` are never high together. Both are registered (decoded from state) with no combinational path from `start`.
- Reset mid-SHIFT or in DONE:
  - FSM returns to IDLE on the next edge.
  - No `done` pulse is issued.
  - `sum`, `cout` and `ovf` are cleared to 0.
- `start` and `reset` high on the same edge: reset wins, and the FSM stays in IDLE.
- Operand inputs may change freely after the accepted start edge without affecting the result.

## Test plan
- Basic add: WIDTH=4, `a_in`=3, `b_in`=5, `cin`=0, pulse `start`.
  - `busy` is high for 4 cycles.
  - `done` pulses at start+5.
  - Result: `sum`=8, `cout`=0, `ovf`=1 (3+5 overflows the signed 4-bit range).
- Wrap with carry: `a_in`=15, `b_in`=1, `cin`=0 → `sum`=0, `cout`=1, `ovf`=0.
- Carry-in path: `a_in`=15, `b_in`=15, `cin`=1 → `sum`=15, `cout`=1, `ovf`=0.
- Start while busy:
  - First add `a_in`=2, `b_in`=2.
  - Re-pulse `start` with `a_in`=9 during SHIFT.
  - Required: exactly one `done`, `sum`=4; the FSM returns to IDLE with no second `busy`.
- Reset mid-operation:
  - Start `a_in`=7, `b_in`=7, then assert `reset` in the 2nd SHIFT cycle.
  - Required: next cycle is IDLE, `busy`=0, no `done`, `sum`=0.
  - A subsequent add of 1+1 gives `sum`=2.
- Back-to-back: start again on the first IDLE cycle after `done` (`a_in`=6, `b_in`=4).
  - Required: accepted; `done` pulses at WIDTH+1 cycles later with `sum`=10, `cout`=0, `ovf`=1.
  - The previous `sum` is held until that edge.
